// File: rtl/alu_multibyte_sequencer.sv
// Byte-serial sequencer wrapping the 8-bit combinational ALU: runs an NBYTES-wide
// operation least significant byte first, chaining carry and aggregating the zero flag.
module alu_multibyte_sequencer #(
  parameter int NBYTES = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Mode,
  input  logic [3:0]          Selector,
  input  logic [8*NBYTES-1:0] A,
  input  logic [8*NBYTES-1:0] B,
  input  logic                CarryIn,
  output logic                Busy,
  output logic                Done,
  output logic [8*NBYTES-1:0] F,
  output logic                CarryOut,
  output logic                ZeroFlag,
  output logic                AluMode,
  output logic [3:0]          AluSelector,
  output logic [7:0]          AluA,
  output logic [7:0]          AluB,
  output logic                AluCarryIn,
  input  logic [7:0]          AluF,
  input  logic                AluCarryOut,
  input  logic                AluZeroFlag
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [KW-1:0] k_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          mode_reg;
  logic [3:0]    sel_reg;
  logic [7:0]    alu_a_reg;
  logic [7:0]    alu_b_reg;
  // Doubles as the carry chain register: holds the previous byte's carry during EXEC.
  logic          alu_cin_reg;
  logic          zacc_reg;
  logic          cout_reg;
  logic          zf_reg;

  logic [KW-1:0] k_inc;
  logic [7:0]    a_next_byte;
  logic [7:0]    b_next_byte;
  logic          zacc_next;
  logic          is_last;

  assign k_inc   = k_reg + KW'(1);
  assign is_last = (k_reg == K_LAST);
  assign zacc_next = (k_reg == '0) ? AluZeroFlag : (zacc_reg & AluZeroFlag);

  always_comb begin
    a_next_byte = 8'h00;
    b_next_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (k_inc == KW'(i)) begin
        a_next_byte = a_reg[8*i +: 8];
        b_next_byte = b_reg[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg   <= IDLE;
      k_reg       <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      mode_reg    <= 1'b0;
      sel_reg     <= 4'h0;
      alu_a_reg   <= 8'h00;
      alu_b_reg   <= 8'h00;
      alu_cin_reg <= 1'b0;
      zacc_reg    <= 1'b0;
      cout_reg    <= 1'b0;
      zf_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            a_reg       <= A;
            b_reg       <= B;
            mode_reg    <= Mode;
            sel_reg     <= Selector;
            k_reg       <= '0;
            // Byte 0 is presented straight from the inputs so the ALU sees it next cycle.
            alu_a_reg   <= A[7:0];
            alu_b_reg   <= B[7:0];
            alu_cin_reg <= CarryIn;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          zacc_reg <= zacc_next;
          if (is_last) begin
            cout_reg    <= AluCarryOut;
            zf_reg      <= zacc_next;
            alu_a_reg   <= 8'h00;
            alu_b_reg   <= 8'h00;
            alu_cin_reg <= 1'b0;
            state_reg   <= DONE;
          end else begin
            k_reg       <= k_inc;
            alu_a_reg   <= a_next_byte;
            alu_b_reg   <= b_next_byte;
            alu_cin_reg <= AluCarryOut;
          end
        end
        DONE: begin
          k_reg     <= '0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Each result byte captures the ALU output only during its own byte cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_fbyte
      logic [7:0] f_byte_reg;
      always_ff @(posedge Clock) begin
        if (Reset) begin
          f_byte_reg <= 8'h00;
        end else if (state_reg == EXEC && k_reg == KW'(gi)) begin
          f_byte_reg <= AluF;
        end
      end
      assign F[8*gi +: 8] = f_byte_reg;
    end
  endgenerate

  assign Busy        = (state_reg != IDLE);
  assign Done        = (state_reg == DONE);
  assign CarryOut    = cout_reg;
  assign ZeroFlag    = zf_reg;
  assign AluMode     = mode_reg;
  assign AluSelector = sel_reg;
  assign AluA        = alu_a_reg;
  assign AluB        = alu_b_reg;
  assign AluCarryIn  = alu_cin_reg;

endmodule

// File: tb/tb_alu_multibyte_sequencer.sv
// Bench for alu_multibyte_sequencer: adder ALU model in the loop, whole-word arithmetic as reference.
module tb_alu_multibyte_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // NBYTES=2 instance
  logic        start0, mode0, cin0;
  logic [3:0]  sel0;
  logic [15:0] a0, b0;
  logic        busy0, done0, cout0, zf0, alu_mode0, alu_cin0;
  logic [15:0] f0;
  logic [3:0]  alu_sel0;
  logic [7:0]  alu_a0, alu_b0;
  logic [8:0]  alu_sum0;
  assign alu_sum0 = {1'b0, alu_a0} + {1'b0, alu_b0} + {8'h00, alu_cin0};

  alu_multibyte_sequencer #(.NBYTES(2)) dut0 (
    .Clock(clk), .Reset(rst), .Start(start0), .Mode(mode0), .Selector(sel0),
    .A(a0), .B(b0), .CarryIn(cin0), .Busy(busy0), .Done(done0), .F(f0),
    .CarryOut(cout0), .ZeroFlag(zf0), .AluMode(alu_mode0), .AluSelector(alu_sel0),
    .AluA(alu_a0), .AluB(alu_b0), .AluCarryIn(alu_cin0), .AluF(alu_sum0[7:0]),
    .AluCarryOut(alu_sum0[8]), .AluZeroFlag(alu_sum0[7:0] == 8'h00)
  );

  // NBYTES=1 instance
  logic        start1, mode1, cin1;
  logic [3:0]  sel1;
  logic [7:0]  a1, b1;
  logic        busy1, done1, cout1, zf1, alu_mode1, alu_cin1;
  logic [7:0]  f1;
  logic [3:0]  alu_sel1;
  logic [7:0]  alu_a1, alu_b1;
  logic [8:0]  alu_sum1;
  assign alu_sum1 = {1'b0, alu_a1} + {1'b0, alu_b1} + {8'h00, alu_cin1};

  alu_multibyte_sequencer #(.NBYTES(1)) dut1 (
    .Clock(clk), .Reset(rst), .Start(start1), .Mode(mode1), .Selector(sel1),
    .A(a1), .B(b1), .CarryIn(cin1), .Busy(busy1), .Done(done1), .F(f1),
    .CarryOut(cout1), .ZeroFlag(zf1), .AluMode(alu_mode1), .AluSelector(alu_sel1),
    .AluA(alu_a1), .AluB(alu_b1), .AluCarryIn(alu_cin1), .AluF(alu_sum1[7:0]),
    .AluCarryOut(alu_sum1[8]), .AluZeroFlag(alu_sum1[7:0] == 8'h00)
  );

  int passed = 0;
  int total  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Full two-byte operation with fixed-latency checks against whole-word arithmetic.
  task automatic op2(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic cin, input logic md, input logic [3:0] sl);
    logic [16:0] sum;
    logic        low_carry;
    sum       = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
    low_carry = ({1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h00, cin}) > 9'd255;
    a0 = a; b0 = b; cin0 = cin; mode0 = md; sel0 = sl; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    a0 = 16'h5A5A; b0 = 16'hA5A5; cin0 = ~cin; mode0 = ~md; sel0 = ~sl;
    chk({tag, ".busy0"}, busy0, 1'b1);
    chk({tag, ".alua0"}, alu_a0, a[7:0]);
    chk({tag, ".cin0"}, alu_cin0, cin);
    chk({tag, ".mode"}, alu_mode0, md);
    chk({tag, ".sel"}, alu_sel0, sl);
    tick();
    chk({tag, ".alub1"}, alu_b0, b[15:8]);
    chk({tag, ".cin1"}, alu_cin0, low_carry);
    chk({tag, ".done_early"}, done0, 1'b0);
    tick();
    chk({tag, ".done"}, done0, 1'b1);
    chk({tag, ".f"}, f0, sum[15:0]);
    chk({tag, ".cout"}, cout0, sum[16]);
    chk({tag, ".zf"}, zf0, sum[15:0] == 16'h0000);
    chk({tag, ".alua_done"}, alu_a0, 8'h00);
    tick();
    chk({tag, ".done_pulse"}, done0, 1'b0);
    chk({tag, ".idle"}, busy0, 1'b0);
    chk({tag, ".hold_f"}, f0, sum[15:0]);
    $display("op %s a=%04h b=%04h cin=%0d -> f=%04h co=%0d zf=%0d", tag, a, b, cin, f0, cout0, zf0);
  endtask

  initial begin
    int pulses[$];
    logic [16:0] r;
    rst = 1'b1;
    start0 = 1'b0; mode0 = 1'b0; sel0 = 4'h0; a0 = '0; b0 = '0; cin0 = 1'b0;
    start1 = 1'b0; mode1 = 1'b0; sel1 = 4'h0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.busy", busy0, 1'b0);
    chk("rst.done", done0, 1'b0);
    chk("rst.f", f0, 16'h0000);
    chk("rst.cout", cout0, 1'b0);
    chk("rst.zf", zf0, 1'b0);
    chk("rst.alua", alu_a0, 8'h00);
    chk("rst.alucin", alu_cin0, 1'b0);
    chk("rst.f1", f1, 8'h00);
    $display("reset checked");

    op2("carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, 4'h9);
    op2("full_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b1, 4'h3);
    op2("partial_zero", 16'h1200, 16'h0000, 1'b0, 1'b0, 4'h0);
    op2("cin_in",      16'h7FFF, 16'h8000, 1'b1, 1'b1, 4'hF);

    for (int i = 0; i < 8; i++) begin
      op2($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 1'($urandom),
          1'($urandom), 4'($urandom));
    end

    // Start during EXEC must be ignored
    a0 = 16'h0001; b0 = 16'h0001; cin0 = 1'b0; start0 = 1'b1;
    tick();
    a0 = 16'hAAAA; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    chk("busy_start.done", done0, 1'b1);
    chk("busy_start.f", f0, 16'h0002);
    tick();
    chk("busy_start.not_queued", busy0, 1'b0);
    tick();
    chk("busy_start.still_idle", busy0, 1'b0);
    $display("start-while-busy ignored f=%04h", f0);

    // Start held high: back-to-back accepts
    a0 = 16'h1111; b0 = 16'h2222; start0 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done0) pulses.push_back(c);
    end
    start0 = 1'b0;
    chk("b2b.pulses", pulses.size(), 3);
    if (pulses.size() >= 2) chk("b2b.spacing", pulses[1] - pulses[0], 4);
    chk("b2b.f", f0, 16'h3333);
    for (int c = 0; c < 6 && busy0; c++) tick();
    chk("b2b.drained", busy0, 1'b0);
    $display("back-to-back done pulses=%0d", pulses.size());

    // Reset mid-EXEC, simultaneous Start
    a0 = 16'h1234; b0 = 16'h1111; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    chk("midrst.in_byte1", alu_a0, 8'h12);
    rst = 1'b1; start0 = 1'b1;
    tick();
    rst = 1'b0; start0 = 1'b0;
    chk("midrst.busy", busy0, 1'b0);
    chk("midrst.done", done0, 1'b0);
    chk("midrst.f", f0, 16'h0000);
    chk("midrst.cout", cout0, 1'b0);
    chk("midrst.alua", alu_a0, 8'h00);
    tick();
    chk("midrst.no_accept", busy0, 1'b0);
    $display("mid-operation reset checked");

    // Single-byte instance
    a1 = 8'h80; b1 = 8'h80; cin1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("nb1.busy", busy1, 1'b1);
    chk("nb1.done_early", done1, 1'b0);
    tick();
    chk("nb1.done", done1, 1'b1);
    chk("nb1.f", f1, 8'h01);
    chk("nb1.cout", cout1, 1'b1);
    chk("nb1.zf", zf1, 1'b0);
    tick();
    chk("nb1.idle", busy1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom); start1 = 1'b1;
      r = {9'h000, a1} + {9'h000, b1} + {16'h0000, cin1};
      tick();
      start1 = 1'b0;
      tick();
      chk($sformatf("nb1.r%0d.done", i), done1, 1'b1);
      chk($sformatf("nb1.r%0d.f", i), f1, r[7:0]);
      chk($sformatf("nb1.r%0d.cout", i), cout1, r[8]);
      chk($sformatf("nb1.r%0d.zf", i), zf1, r[7:0] == 8'h00);
      tick();
      $display("nb1 op a=%02h b=%02h cin=%0d -> f=%02h co=%0d", a1, b1, cin1, f1, cout1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
